// File: rtl/fetch_if.sv
// Fetch-stage bundle: ROM port, hazard/decode controls and IF/ID outputs.
// master = fetch stage, slave = ROM/decode/hazard side.
interface fetch_if #(
    parameter int IMEM_AW = 8
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_data;
    logic               stall;
    logic               is_jump;
    logic               branch_taken;
    logic [29:0]        pc;
    logic [31:0]        id_instr;
    logic [29:0]        id_pc_plus1;
    logic               id_valid;
    logic [15:0]        squash_count;

    modport master (
        output imem_addr, pc, id_instr,
        output id_pc_plus1, id_valid, squash_count,
        input  imem_data, stall, is_jump, branch_taken
    );

    modport slave (
        input  imem_addr, pc, id_instr,
        input  id_pc_plus1, id_valid, squash_count,
        output imem_data, stall, is_jump, branch_taken
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register, 1-bubble redirect on
// jump/taken branch resolved in decode, and stall hold.
module fetch_stage #(
    parameter logic [29:0] RESET_PC = 30'd0,
    parameter int          IMEM_AW  = 8
) (
    input logic     clk,
    input logic     reset,
    fetch_if.master bus
);
    logic [29:0] r_pc;
    logic [31:0] r_id_instr;
    logic [29:0] r_id_pc_plus1;
    logic        r_id_valid;
    logic [15:0] r_squash_count;

    logic [29:0] w_br_tgt;
    logic [29:0] w_jmp_tgt;
    logic [29:0] w_target;
    logic        w_redirect;

    assign w_br_tgt  = r_id_pc_plus1
                     + {{14{r_id_instr[15]}}, r_id_instr[15:0]};
    assign w_jmp_tgt = {r_id_pc_plus1[29:26], r_id_instr[25:0]};
    assign w_target  = bus.is_jump ? w_jmp_tgt : w_br_tgt;
    assign w_redirect = r_id_valid & ~bus.stall
                      & (bus.is_jump | bus.branch_taken);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc           <= RESET_PC;
            r_id_instr     <= 32'h0;
            r_id_pc_plus1  <= 30'd0;
            r_id_valid     <= 1'b0;
            r_squash_count <= 16'd0;
        end else if (bus.stall) begin
            r_pc           <= r_pc;
        end else if (w_redirect) begin
            // wrong-path word fetched this cycle is dropped
            r_pc           <= w_target;
            r_id_instr     <= 32'h0;
            r_id_pc_plus1  <= 30'd0;
            r_id_valid     <= 1'b0;
            r_squash_count <= r_squash_count + 16'd1;
        end else begin
            r_pc           <= r_pc + 30'd1;
            r_id_instr     <= bus.imem_data;
            r_id_pc_plus1  <= r_pc + 30'd1;
            r_id_valid     <= 1'b1;
        end
    end

    assign bus.imem_addr    = r_pc[IMEM_AW-1:0];
    assign bus.pc           = r_pc;
    assign bus.id_instr     = r_id_instr;
    assign bus.id_pc_plus1  = r_id_pc_plus1;
    assign bus.id_valid     = r_id_valid;
    assign bus.squash_count = r_squash_count;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table plus randomized run
// against a behavioural fetch model.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0] rom [256];

    fetch_if #(.IMEM_AW(8)) bus ();
    fetch_stage #(.RESET_PC(30'd0), .IMEM_AW(8)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    assign bus.imem_data = rom[bus.imem_addr];

    typedef struct {
        logic        rst, st, j, b;
        logic [29:0] pc;
        logic [31:0] instr;
        logic [29:0] pp1;
        logic        v;
        logic [15:0] sq;
    } vec_t;

    vec_t tbl [$];
    int n_vec = 0;
    int n_bad = 0;

    function automatic vec_t mk(logic rst, logic st, logic j,
                                logic b, logic [29:0] pc,
                                logic [31:0] instr,
                                logic [29:0] pp1, logic v,
                                logic [15:0] sq);
        vec_t t;
        t.rst = rst; t.st = st; t.j = j; t.b = b;
        t.pc = pc; t.instr = instr; t.pp1 = pp1;
        t.v = v; t.sq = sq;
        return t;
    endfunction

    task automatic check(string nm, vec_t e);
        n_vec++;
        if (bus.pc !== e.pc || bus.id_instr !== e.instr ||
            bus.id_pc_plus1 !== e.pp1 || bus.id_valid !== e.v ||
            bus.squash_count !== e.sq ||
            bus.imem_addr !== e.pc[7:0]) begin
            n_bad++;
            $display("FAIL %s: got pc=%h instr=%h pp1=%h v=%b sq=%0d addr=%h; want pc=%h instr=%h pp1=%h v=%b sq=%0d",
                     nm, bus.pc, bus.id_instr, bus.id_pc_plus1,
                     bus.id_valid, bus.squash_count, bus.imem_addr,
                     e.pc, e.instr, e.pp1, e.v, e.sq);
        end
    endtask

    task automatic apply(vec_t t, string nm);
        reset = t.rst;
        bus.stall = t.st;
        bus.is_jump = t.j;
        bus.branch_taken = t.b;
        @(posedge clk);
        #1;
        check(nm, t);
    endtask

    task automatic run_tbl(string nm);
        foreach (tbl[i]) apply(tbl[i], $sformatf("%s[%0d]", nm, i));
        tbl.delete();
    endtask

    // behavioural model state
    logic [29:0] m_pc, m_pp1;
    logic [31:0] m_instr;
    logic        m_v;
    logic [15:0] m_sq;

    task automatic model_step(logic rst, logic st, logic j, logic b);
        logic [29:0] tgt;
        if (rst) begin
            m_pc = 0; m_instr = 0; m_pp1 = 0; m_v = 0; m_sq = 0;
        end else if (st) begin
            // hold everything
        end else if (m_v && (j || b)) begin
            if (j) tgt = {m_pp1[29:26], m_instr[25:0]};
            else tgt = m_pp1 + 30'($signed(m_instr[15:0]));
            m_pc = tgt; m_instr = 0; m_pp1 = 0; m_v = 0;
            m_sq = m_sq + 1;
        end else begin
            m_instr = rom[m_pc % 256];
            m_pp1 = m_pc + 1;
            m_v = 1;
            m_pc = m_pc + 1;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.stall = 0; bus.is_jump = 0; bus.branch_taken = 0;
        for (int i = 0; i < 256; i++) rom[i] = 32'h100 + i;

        // sequential, stall, stalled branch, bubble-jump, reset
        tbl.push_back(mk(1,0,0,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,0,0,0, 1, 32'h100, 1, 1, 0));
        tbl.push_back(mk(0,0,0,0, 2, 32'h101, 2, 1, 0));
        tbl.push_back(mk(0,0,0,0, 3, 32'h102, 3, 1, 0));
        tbl.push_back(mk(0,0,0,0, 4, 32'h103, 4, 1, 0));
        tbl.push_back(mk(0,1,0,0, 4, 32'h103, 4, 1, 0));
        tbl.push_back(mk(0,1,0,0, 4, 32'h103, 4, 1, 0));
        tbl.push_back(mk(0,0,0,0, 5, 32'h104, 5, 1, 0));
        tbl.push_back(mk(0,1,0,1, 5, 32'h104, 5, 1, 0));
        tbl.push_back(mk(0,0,0,1, 30'h109, 0, 0, 0, 1));
        tbl.push_back(mk(0,0,1,0, 30'h10A, 32'h109, 30'h10A, 1, 1));
        tbl.push_back(mk(0,0,0,0, 30'h10B, 32'h10A, 30'h10B, 1, 1));
        tbl.push_back(mk(1,1,0,1, 0, 0, 0, 0, 0));
        run_tbl("seqA");

        rom[0] = 32'h0000FFFE;
        rom[2] = 32'h08000020;
        rom[4] = 32'h0000FFFE;
        // pc wrap, jump-over-branch priority, backward branch
        tbl.push_back(mk(1,0,0,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,0,0,0, 1, 32'hFFFE, 1, 1, 0));
        tbl.push_back(mk(0,0,0,1, 30'h3FFFFFFF, 0, 0, 0, 1));
        tbl.push_back(mk(0,0,0,0, 0, 32'h1FF, 0, 1, 1));
        tbl.push_back(mk(0,0,0,0, 1, 32'hFFFE, 1, 1, 1));
        tbl.push_back(mk(0,0,0,0, 2, 32'h101, 2, 1, 1));
        tbl.push_back(mk(0,0,0,0, 3, 32'h08000020, 3, 1, 1));
        tbl.push_back(mk(0,0,1,1, 30'h20, 0, 0, 0, 2));
        tbl.push_back(mk(0,0,0,0, 30'h21, 32'h120, 30'h21, 1, 2));
        tbl.push_back(mk(1,0,0,0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,0,0,0, 1, 32'hFFFE, 1, 1, 0));
        tbl.push_back(mk(0,0,0,0, 2, 32'h101, 2, 1, 0));
        tbl.push_back(mk(0,0,0,0, 3, 32'h08000020, 3, 1, 0));
        tbl.push_back(mk(0,0,0,0, 4, 32'h103, 4, 1, 0));
        tbl.push_back(mk(0,0,0,0, 5, 32'hFFFE, 5, 1, 0));
        tbl.push_back(mk(0,0,0,1, 3, 0, 0, 0, 1));
        tbl.push_back(mk(0,0,0,0, 4, 32'h103, 4, 1, 1));
        run_tbl("seqB");

        // randomized run against the model
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        m_pc = 0; m_instr = 0; m_pp1 = 0; m_v = 0; m_sq = 0;
        apply(mk(1,0,0,0, 0, 0, 0, 0, 0), "rnd_reset");
        for (int k = 0; k < 3000; k++) begin
            vec_t t;
            t.rst = ($urandom_range(0, 99) == 0);
            t.st = ($urandom_range(0, 3) == 0);
            t.j = ($urandom_range(0, 7) == 0);
            t.b = ($urandom_range(0, 5) == 0);
            model_step(t.rst, t.st, t.j, t.b);
            t.pc = m_pc; t.instr = m_instr; t.pp1 = m_pp1;
            t.v = m_v; t.sq = m_sq;
            apply(t, $sformatf("rnd[%0d]", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Pipelined instruction-fetch stage with the IF/ID pipeline register. Feeds the decode/control stage directly downstream.
- Holds the word-addressed PC and drives the combinational instruction ROM. Latches the fetched word with its PC+1.
- Redirects on jump or taken branch resolved in decode, with a one-cycle squash. Honours a stall from hazard logic and counts squashed slots.

Parameters:
RESET_PC, 30'd0, word address loaded into pc on reset
IMEM_AW, 8, instruction ROM address width; imem_addr = pc[IMEM_AW-1:0]

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
imem_addr  output  IMEM_AW  address to combinational instruction ROM
imem_data  input  32  instruction word returned by ROM, same cycle
stall  input  1  hazard unit: hold PC and IF/ID this cycle
is_jump  input  1  decode: instruction in IF/ID is j
branch_taken  input  1  decode: instruction in IF/ID is a taken branch
pc  output  30  current fetch PC (word address)
id_instr  output  32  IF/ID instruction register
id_pc_plus1  output  30  IF/ID copy of fetch PC + 1
id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
squash_count  output  16  number of wrong-path slots squashed

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high (reset). It overrides every other input.
  - On reset: pc=RESET_PC, id_instr=32'h0 (NOP), id_pc_plus1=0, id_valid=0, squash_count=0.
- Addressing and arithmetic:
  - imem_addr = pc[IMEM_AW-1:0], combinational. Higher pc bits alias.
  - All PC arithmetic is 30-bit, modulo 2^30. pc=30'h3FFFFFFF increments to 0.
  - imm16 = id_instr[15:0]. addr26 = id_instr[25:0].
  - Branch target = id_pc_plus1 + sign_extend_30(imm16).
  - Jump target = {id_pc_plus1[29:26], addr26}.
- Redirect:
  - redirect = id_valid & (is_jump | branch_taken) & ~stall.
  - If both is_jump and branch_taken are set, the jump target wins.
  - is_jump and branch_taken are ignored while id_valid=0.
- Per posedge, in priority order:
  1. reset: reset values as above.
  2. stall=1: pc, id_instr, id_pc_plus1, id_valid all hold. Redirect is suppressed even if is_jump or branch_taken is asserted, because decode is not resolved while stalled. squash_count holds.
  3. redirect: pc <= target; id_instr <= 0; id_valid <= 0; id_pc_plus1 <= 0; squash_count <= squash_count+1 (wraps 16'hFFFF -> 0). The word fetched this cycle is discarded. Penalty is exactly 1 bubble; no delay slot.
  4. otherwise: id_instr <= imem_data; id_pc_plus1 <= pc+1; id_valid <= 1; pc <= pc+1.
- Latency: an instruction at PC p appears in id_instr one posedge after pc=p. The first valid id_instr appears on the first posedge after reset deasserts.
- Stall length is unbounded. The stage resumes exactly where it held, and no instruction is lost or duplicated.
- Reset mid-stall or mid-redirect: reset wins, and nothing from that cycle is committed.
- No combinational path from stall, is_jump or branch_taken to any output; all outputs are registered except imem_addr, which depends on pc only.

Test Plan:
- ROM[i]=32'h100+i; release reset -> cycles 1..3: id_instr=0x100,0x101,0x102; id_pc_plus1=1,2,3; id_valid=1; pc=1,2,3.
- Stall=1 for 2 cycles when pc=4 -> pc stays 4 and id_instr stays 0x103 for both cycles; on release id_instr=0x104, pc=5.
- ROM[2]=32'h08000020 (j 0x20), is_jump=1 while it sits in IF/ID -> next cycle pc=0x20, id_valid=0, id_instr=0, squash_count=1; following cycle id_instr=ROM[0x20], id_pc_plus1=0x21.
- id_pc_plus1=5, id_instr imm16=16'hFFFE, branch_taken=1 -> pc=3, one bubble; then id_instr=ROM[3]. Also force pc=30'h3FFFFFFF -> next pc=0.
- stall=1 together with branch_taken=1 -> no redirect, squash_count unchanged; drop stall next cycle -> redirect taken then.
- is_jump=1 while id_valid=0 -> ignored, sequential fetch continues. Assert reset mid-stream -> next cycle pc=RESET_PC, id_valid=0, squash_count=0.
